// File: rtl/dz_tx_scanner_if.sv
// DZ11 transmitter-scanner bus: CSR/TCR/TDR side and per-line UART
// transmitter signals. The master drives the register-side controls and
// the UART empty flags; the scanner (slave) returns the ready/line status
// and the load strobe and byte for the UARTs.
interface dz_tx_scanner_if;
  logic       clr;          // synchronous clear (CSR[CLR] or UBA INI)
  logic       csrMSE;       // master scan enable
  logic [7:0] tcrLIN;       // per-line transmit enable
  logic [7:0] uartTXEMPTY;  // per-line UART transmitter empty
  logic       tdrWRITE;     // TDR write strobe (level)
  logic [7:0] tdrDATA;      // TDR data byte
  logic       csrTRDY;      // transmitter ready
  logic [2:0] csrTLINE;     // line being offered
  logic [7:0] uartTXLOAD;   // one-hot, one-clock load strobe
  logic [7:0] uartTXDATA;   // byte to load

  modport master (
    output clr, csrMSE, tcrLIN, uartTXEMPTY, tdrWRITE, tdrDATA,
    input  csrTRDY, csrTLINE, uartTXLOAD, uartTXDATA
  );

  modport slave (
    input  clr, csrMSE, tcrLIN, uartTXEMPTY, tdrWRITE, tdrDATA,
    output csrTRDY, csrTLINE, uartTXLOAD, uartTXDATA
  );
endinterface

// File: rtl/dz_tx_scanner.sv
// DZ11 transmitter scanner. Walks the eight lines round-robin, one line per
// scan step, looking for one that is enabled and has an empty transmitter.
// The found line is offered through csrTRDY/csrTLINE; the next rising edge
// of the TDR write strobe loads the TDR byte into that line's UART. After a
// load the scanner waits for the UART to accept the byte and resumes just
// past the served line, so that line is examined last.
module dz_tx_scanner #(
  parameter int unsigned SCANDIV = 4  // clocks per scan step, 1..255
) (
  input  logic            clk,
  input  logic            rst,
  dz_tx_scanner_if.slave  bus
);

  localparam logic [7:0] DIV_LAST = 8'(SCANDIV - 1);

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_READY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [7:0] div_q,   div_d;
  logic       trdy_q,  trdy_d;
  logic [2:0] tline_q, tline_d;
  logic [7:0] load_q,  load_d;
  logic [7:0] data_q,  data_d;
  logic       wr_q;

  logic       step;
  logic       elig_ptr;
  logic       wr_rise;
  logic       line_off;

  assign elig_ptr = bus.csrMSE & bus.tcrLIN[ptr_q] & bus.uartTXEMPTY[ptr_q];
  assign wr_rise  = bus.tdrWRITE & ~wr_q;
  // The offered line loses its offer when scanning stops or its TCR bit drops.
  assign line_off = ~bus.csrMSE | ~bus.tcrLIN[tline_q];

  // Next-state and output logic; the TCR/MSE drop takes priority over a
  // write edge in the same clock, and clr overrides everything.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    div_d   = '0;
    trdy_d  = trdy_q;
    tline_d = tline_q;
    load_d  = '0;
    data_d  = data_q;
    step    = 1'b0;

    if (state_q == ST_SCAN && bus.csrMSE) begin
      if (div_q == DIV_LAST) begin
        step = 1'b1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    case (state_q)
      ST_SCAN: begin
        if (step) begin
          if (elig_ptr) begin
            tline_d = ptr_q;
            trdy_d  = 1'b1;
            state_d = ST_READY;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end

      ST_READY: begin
        if (line_off) begin
          trdy_d  = 1'b0;
          ptr_d   = tline_q + 3'd1;
          state_d = ST_SCAN;
        end else if (wr_rise) begin
          load_d  = 8'(1) << tline_q;
          data_d  = bus.tdrDATA;
          trdy_d  = 1'b0;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // Leave only once the write has ended and the UART has taken the byte.
        if (!bus.tdrWRITE && !bus.uartTXEMPTY[tline_q]) begin
          ptr_d   = tline_q + 3'd1;
          state_d = ST_SCAN;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase

    if (bus.clr) begin
      state_d = ST_SCAN;
      ptr_d   = '0;
      div_d   = '0;
      trdy_d  = 1'b0;
      tline_d = '0;
      load_d  = '0;
      data_d  = '0;
    end
  end

  // State and registered outputs; the write-edge detector samples every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SCAN;
      ptr_q   <= '0;
      div_q   <= '0;
      trdy_q  <= 1'b0;
      tline_q <= '0;
      load_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      div_q   <= div_d;
      trdy_q  <= trdy_d;
      tline_q <= tline_d;
      load_q  <= load_d;
      data_q  <= data_d;
      wr_q    <= bus.tdrWRITE;
    end
  end

  assign bus.csrTRDY    = trdy_q;
  assign bus.csrTLINE   = tline_q;
  assign bus.uartTXLOAD = load_q;
  assign bus.uartTXDATA = data_q;

endmodule

// File: tb/tb_dz_tx_scanner.sv
// Bench for dz_tx_scanner: directed stimulus with a scoreboard of expected
// UART loads and expected line offers, plus a small UART model that drops
// TXEMPTY for a while after each load.
module tb_dz_tx_scanner;
  localparam int SCANDIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dz_tx_scanner_if bus();

  dz_tx_scanner #(.SCANDIV(SCANDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [2:0] line;
    logic [7:0] data;
  } load_t;

  load_t      exp_load_q[$];
  logic [2:0] exp_offer_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] base_empty;
  int         busy_len;
  int         busy[8];
  logic       trdy_prev = 1'b0;
  load_t      mon_load;
  logic [2:0] mon_line;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance past the edge, then update the UART empty model.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int n = 0; n < 8; n++) begin
      if (bus.uartTXLOAD[n]) busy[n] = busy_len;
      bus.uartTXEMPTY[n] = base_empty[n] & (busy[n] == 0);
      if (busy[n] > 0) busy[n]--;
    end
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic wait_trdy(input int limit, input string tag);
    int k;
    k = 0;
    while (!bus.csrTRDY && k < limit) begin
      tick();
      k++;
    end
    check(tag, 32'(bus.csrTRDY), 32'd1);
  endtask

  task automatic wr_pulse(input logic [2:0] line, input logic [7:0] d);
    load_t e;
    e.line = line;
    e.data = d;
    exp_load_q.push_back(e);
    bus.tdrDATA  = d;
    bus.tdrWRITE = 1'b1;
    tick();
    bus.tdrWRITE = 1'b0;
  endtask

  // Scoreboard: every load strobe and every new offer is matched to the
  // oldest expectation.
  always @(negedge clk) begin
    if (bus.uartTXLOAD != 8'h00) begin
      if (exp_load_q.size() == 0) begin
        check("unexpected_load", 32'(bus.uartTXLOAD), 32'd0);
      end else begin
        mon_load = exp_load_q.pop_front();
        check("load_strobe", 32'(bus.uartTXLOAD), 32'(1) << mon_load.line);
        check("load_data", 32'(bus.uartTXDATA), 32'(mon_load.data));
      end
    end
    if (bus.csrTRDY && !trdy_prev && exp_offer_q.size() > 0) begin
      mon_line = exp_offer_q.pop_front();
      check("offer_line", 32'(bus.csrTLINE), 32'(mon_line));
    end
    trdy_prev = bus.csrTRDY;
  end

  initial begin
    int seen;
    rst              = 1'b1;
    bus.clr          = 1'b0;
    bus.csrMSE       = 1'b0;
    bus.tcrLIN       = 8'h00;
    bus.uartTXEMPTY  = 8'hFF;
    bus.tdrWRITE     = 1'b0;
    bus.tdrDATA      = 8'h00;
    base_empty       = 8'hFF;
    busy_len         = 2;
    for (int n = 0; n < 8; n++) busy[n] = 0;

    // Reset state
    repeat (3) tick();
    check("rst_trdy",  32'(bus.csrTRDY),    32'd0);
    check("rst_tline", 32'(bus.csrTLINE),   32'd0);
    check("rst_load",  32'(bus.uartTXLOAD), 32'd0);
    check("rst_data",  32'(bus.uartTXDATA), 32'd0);
    rst = 1'b0;
    tick();

    // Single line 3: offer within 4*SCANDIV+2 clocks, then a 3-clock write
    bus.csrMSE = 1'b1;
    bus.tcrLIN = 8'h08;
    busy_len   = 6;
    exp_offer_q.push_back(3'd3);
    wait_trdy(4 * SCANDIV + 2, "single_trdy");
    check("single_tline", 32'(bus.csrTLINE), 32'd3);
    begin
      load_t e;
      e.line = 3'd3;
      e.data = 8'h41;
      exp_load_q.push_back(e);
    end
    bus.tdrDATA  = 8'h41;
    bus.tdrWRITE = 1'b1;
    tick();
    check("single_trdy_drop", 32'(bus.csrTRDY), 32'd0);
    tick();
    check("single_load_one_clk", 32'(bus.uartTXLOAD), 32'd0);
    tick();
    bus.tdrWRITE = 1'b0;
    check("single_data_held", 32'(bus.uartTXDATA), 32'h41);
    repeat (2) tick();
    do_clr();

    // Round robin between lines 0 and 7
    bus.tcrLIN = 8'h81;
    busy_len   = 2;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] ln;
      ln = (i % 2 == 1) ? 3'd7 : 3'd0;
      exp_offer_q.push_back(ln);
      wait_trdy(8 * SCANDIV + 8, "rr_trdy");
      wr_pulse(ln, 8'(8'h10 + i));
    end
    repeat (3) tick();
    do_clr();

    // TCR drop in the same clock as the write edge: no load, resume at line 3
    bus.tcrLIN = 8'h04;
    exp_offer_q.push_back(3'd2);
    wait_trdy(3 * SCANDIV + 3, "drop_trdy");
    bus.tdrDATA  = 8'hEE;
    bus.tdrWRITE = 1'b1;
    bus.tcrLIN   = 8'h00;
    tick();
    check("drop_trdy_low", 32'(bus.csrTRDY), 32'd0);
    bus.tdrWRITE = 1'b0;
    bus.tcrLIN   = 8'h0C;
    exp_offer_q.push_back(3'd3);
    wait_trdy(SCANDIV + 3, "drop_resume_trdy");
    do_clr();

    // Write level already high when READY is entered
    bus.tdrWRITE = 1'b1;
    bus.tcrLIN   = 8'h02;
    exp_offer_q.push_back(3'd1);
    wait_trdy(2 * SCANDIV + 3, "held_trdy");
    repeat (3) tick();
    check("held_still_ready", 32'(bus.csrTRDY), 32'd1);
    bus.tdrWRITE = 1'b0;
    tick();
    wr_pulse(3'd1, 8'h5A);
    repeat (4) tick();
    check("held_one_load", 32'(exp_load_q.size()), 32'd0);
    do_clr();

    // Scan disabled: no offer in 100 clocks, pointer stays at 0
    bus.csrMSE = 1'b0;
    bus.tcrLIN = 8'hFF;
    seen = 0;
    repeat (100) begin
      tick();
      if (bus.csrTRDY) seen++;
    end
    check("mse_off_trdy", 32'(seen), 32'd0);
    bus.csrMSE = 1'b1;
    exp_offer_q.push_back(3'd0);
    wait_trdy(SCANDIV + 3, "mse_on_trdy");
    bus.tcrLIN = 8'hFE;
    tick();
    check("mse_drop_trdy", 32'(bus.csrTRDY), 32'd0);
    exp_offer_q.push_back(3'd1);
    wait_trdy(SCANDIV + 3, "next_line_trdy");
    bus.tcrLIN = 8'hFF;

    // clr while in HOLD (write held high, UART busy): back to SCAN at line 0
    busy_len = 40;
    begin
      load_t e;
      e.line = 3'd1;
      e.data = 8'h77;
      exp_load_q.push_back(e);
    end
    bus.tdrDATA  = 8'h77;
    bus.tdrWRITE = 1'b1;
    tick();
    tick();
    check("hold_trdy", 32'(bus.csrTRDY), 32'd0);
    exp_offer_q.push_back(3'd0);
    do_clr();
    wait_trdy(SCANDIV + 3, "clr_hold_trdy");
    bus.tdrWRITE = 1'b0;
    tick();
    do_clr();
    for (int n = 0; n < 8; n++) busy[n] = 0;
    busy_len = 2;

    // Asynchronous reset while offering line 5
    bus.tcrLIN = 8'h20;
    exp_offer_q.push_back(3'd5);
    wait_trdy(6 * SCANDIV + 3, "arst_trdy");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_trdy_low", 32'(bus.csrTRDY),    32'd0);
    check("arst_tline",    32'(bus.csrTLINE),   32'd0);
    check("arst_load",     32'(bus.uartTXLOAD), 32'd0);
    tick();
    rst        = 1'b0;
    bus.tcrLIN = 8'h21;
    exp_offer_q.push_back(3'd0);
    wait_trdy(SCANDIV + 3, "arst_restart_trdy");
    repeat (2) tick();

    check("load_queue_empty",  32'(exp_load_q.size()),  32'd0);
    check("offer_queue_empty", 32'(exp_offer_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
